// File: rtl/radix4_pkg.sv
// Shared types and helpers for the radix-4 divider: FSM state encoding,
// default width and a sign-magnitude conversion function.
package radix4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } div_state_t;

    localparam int DIV_W_DEFAULT = 8;
    localparam int DIV_MAX_W     = 64;

    // Magnitude of a sign-extended value, one bit wider so the most negative input stays exact.
    function automatic logic [DIV_MAX_W:0] abs_ext(input logic [DIV_MAX_W-1:0] v);
        logic [DIV_MAX_W:0] ext;
        ext = {v[DIV_MAX_W-1], v};
        if (v[DIV_MAX_W-1]) begin
            abs_ext = ~ext + 1'b1;
        end else begin
            abs_ext = ext;
        end
    endfunction

endpackage

// File: rtl/radix4_div_step.sv
// One radix-4 restoring step: picks the largest of 0/d/2d/3d not above the
// partial remainder and returns the digit and the reduced remainder.
module radix4_div_step #(
    parameter int W = 8
) (
    input  logic [W+1:0] p_i,
    input  logic [W-1:0] d_i,
    output logic [1:0]   q_o,
    output logic [W-1:0] p_o
);

    logic [W+2:0] p_ext;
    logic [W+2:0] d1;
    logic [W+2:0] d2;
    logic [W+2:0] d3;
    logic [W+2:0] s1;
    logic [W+2:0] s2;
    logic [W+2:0] s3;
    logic [W+2:0] sel;
    logic         unused_hi;

    assign p_ext = {1'b0, p_i};
    assign d1    = {3'b000, d_i};
    assign d2    = {2'b00, d_i, 1'b0};
    assign d3    = d1 + d2;

    // Top bit of each difference is the borrow: set means that multiple is too large.
    assign s1 = p_ext - d1;
    assign s2 = p_ext - d2;
    assign s3 = p_ext - d3;

    always_comb begin
        q_o = 2'd0;
        sel = p_ext;
        if (!s3[W+2]) begin
            q_o = 2'd3;
            sel = s3;
        end else if (!s2[W+2]) begin
            q_o = 2'd2;
            sel = s2;
        end else if (!s1[W+2]) begin
            q_o = 2'd1;
            sel = s1;
        end
    end

    // The reduced remainder is always below d, so only the low W bits carry information.
    assign p_o       = sel[W-1:0];
    assign unused_hi = ^sel[W+2:W];

endmodule

// File: rtl/radix_4_divider.sv
// Sequential signed radix-4 divider: 2W-bit dividend by W-bit divisor, two
// quotient bits per cycle. Define DIV_FLAGS_EN to add div_zero/overflow outputs.
module radix_4_divider
    import radix4_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
`ifdef DIV_FLAGS_EN
    output logic           div_zero,
    output logic           overflow,
`endif
    output logic           ready
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;

    div_state_t     state_q, state_d;
    logic           start_q;
    logic           accept;

    logic [2*W-1:0] dividend_q;
    logic [W-1:0]   divisor_q;
    logic           dvd_neg_q;
    logic           dvs_neg_q;
    logic [2*W:0]   pdvd_q;
    logic [W-1:0]   dmag_q;
    logic [W-1:0]   prem_q;
    logic [2*W-1:0] qacc_q;
    logic [CW-1:0]  cnt_q;

    logic [2*W-1:0] quotient_q;
    logic [W-1:0]   remainder_q;
    logic           ready_q;
    logic           div_zero_q;
    logic           overflow_q;

    logic [DIV_MAX_W:0] dvd_abs;
    logic [DIV_MAX_W:0] dvs_abs;
    logic               unused_abs;

    logic [W+1:0]   step_p;
    logic [1:0]     step_q;
    logic [W-1:0]   step_rem;

    logic           q_neg;
    logic           dvs_zero;
    logic [2*W-1:0] q_fix;
    logic [W-1:0]   r_fix;

    assign dvd_abs    = abs_ext({{(DIV_MAX_W-2*W){dividend_q[2*W-1]}}, dividend_q});
    assign dvs_abs    = abs_ext({{(DIV_MAX_W-W){divisor_q[W-1]}}, divisor_q});
    assign unused_abs = ^{dvd_abs[DIV_MAX_W:2*W+1], dvs_abs[DIV_MAX_W:W]};

    // The result cycle still counts as busy, so an edge seen alongside ready is dropped.
    assign accept = start & ~start_q & (state_q == IDLE) & ~ready_q;

    assign step_p = {prem_q, pdvd_q[2*W-1 -: 2]};

    radix4_div_step #(.W(W)) u_step (
        .p_i (step_p),
        .d_i (dmag_q),
        .q_o (step_q),
        .p_o (step_rem)
    );

    assign q_neg    = dvd_neg_q ^ dvs_neg_q;
    assign dvs_zero = (divisor_q == '0);

    always_comb begin
        q_fix = q_neg ? (~qacc_q + 1'b1) : qacc_q;
        r_fix = dvd_neg_q ? (~prem_q + 1'b1) : prem_q;
        if (dvs_zero) begin
            q_fix = '1;
            r_fix = dividend_q[W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = LOAD;
            LOAD: state_d = ITER;
            ITER: if (cnt_q == '0) state_d = FIX;
            FIX:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            start_q     <= 1'b0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            pdvd_q      <= '0;
            dmag_q      <= '0;
            prem_q      <= '0;
            qacc_q      <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ready_q     <= 1'b0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            start_q <= start;
            ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        dividend_q <= dividend;
                        divisor_q  <= divisor;
                        dvd_neg_q  <= dividend[2*W-1];
                        dvs_neg_q  <= divisor[W-1];
                    end
                end
                LOAD: begin
                    pdvd_q <= dvd_abs[2*W:0];
                    dmag_q <= dvs_abs[W-1:0];
                    prem_q <= '0;
                    qacc_q <= '0;
                    cnt_q  <= CW'(W-1);
                end
                ITER: begin
                    pdvd_q <= pdvd_q << 2;
                    prem_q <= step_rem;
                    qacc_q <= {qacc_q[2*W-3:0], step_q};
                    cnt_q  <= cnt_q - 1'b1;
                end
                FIX: begin
                    quotient_q  <= q_fix;
                    remainder_q <= r_fix;
                    ready_q     <= 1'b1;
                    div_zero_q  <= dvs_zero;
                    // Only a same-sign result of magnitude 2^(2W-1) cannot be represented.
                    overflow_q  <= ~q_neg & qacc_q[2*W-1] & ~dvs_zero;
                end
                default: ;
            endcase
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign ready     = ready_q;

`ifdef DIV_FLAGS_EN
    assign div_zero = div_zero_q;
    assign overflow = overflow_q;
`else
    logic unused_flags;
    assign unused_flags = div_zero_q ^ overflow_q;
`endif

endmodule

// File: tb/tb_radix_4_divider.sv
// Directed-vector bench for radix_4_divider (W=8): latency, signed results,
// divide-by-zero, overflow wrap, back-to-back ops and mid-operation reset.
module tb_radix_4_divider;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        ready;
`ifdef DIV_FLAGS_EN
    logic        div_zero;
    logic        overflow;
`endif

    int tests_run;
    int tests_failed;

    radix_4_divider #(.W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
`ifdef DIV_FLAGS_EN
        .div_zero  (div_zero),
        .overflow  (overflow),
`endif
        .ready     (ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drives one operation; returns at the negedge inside the ready cycle.
    // lat = posedges from the accepting edge to the ready edge, -1 on timeout.
    task automatic do_op(input logic [15:0] a, input logic [7:0] b, input int hold, output int lat);
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        lat = -1;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clock);
            if (n >= hold) start = 1'b0;
            if (ready === 1'b1) begin
                lat = n - 1;
                break;
            end
            @(posedge clock);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        tests_run++;
        if (quotient !== 16'h0000 || remainder !== 8'h00 || ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got q=%h r=%h rdy=%b, want q=0000 r=00 rdy=0", quotient, remainder, ready);
        end
`ifdef DIV_FLAGS_EN
        tests_run++;
        if (div_zero !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got dz=%b ov=%b, want 0 0", div_zero, overflow);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_held_start();
        int lat;
        int pulses;
        do_op(16'hFF88, 8'h03, 3, lat);
        tests_run++;
        if (lat !== 10) begin
            tests_failed++;
            $display("FAIL held_latency: got %0d, want 10", lat);
        end
        tests_run++;
        if (quotient !== 16'hFFD8 || remainder !== 8'h00) begin
            tests_failed++;
            $display("FAIL held_result: got q=%h r=%h, want q=ffd8 r=00", quotient, remainder);
        end
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            if (ready === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL held_single_op: got %0d extra ready pulses, want 0", pulses);
        end
    endtask

    task automatic test_signs();
        logic [15:0] va [5] = '{16'h0064, 16'hFF9C, 16'h0064, 16'hFF9C, 16'h7FFF};
        logic [7:0]  vb [5] = '{8'h07,    8'h07,    8'hF9,    8'hF9,    8'h80};
        logic [15:0] eq [5] = '{16'h000E, 16'hFFF2, 16'hFFF2, 16'h000E, 16'hFF01};
        logic [7:0]  er [5] = '{8'h02,    8'hFE,    8'h02,    8'hFE,    8'h7F};
        int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], 1, lat);
            tests_run++;
            if (lat !== 10 || quotient !== eq[i] || remainder !== er[i]) begin
                tests_failed++;
                $display("FAIL signs_%0d: %h/%h got lat=%0d q=%h r=%h, want lat=10 q=%h r=%h",
                         i, va[i], vb[i], lat, quotient, remainder, eq[i], er[i]);
            end
`ifdef DIV_FLAGS_EN
            tests_run++;
            if (div_zero !== 1'b0 || overflow !== 1'b0) begin
                tests_failed++;
                $display("FAIL signs_flags_%0d: got dz=%b ov=%b, want 0 0", i, div_zero, overflow);
            end
`endif
        end
    endtask

    task automatic test_div_zero();
        int lat;
        do_op(16'h04D2, 8'h00, 1, lat);
        tests_run++;
        if (lat !== 10) begin
            tests_failed++;
            $display("FAIL divzero_latency: got %0d, want 10", lat);
        end
        tests_run++;
        if (quotient !== 16'hFFFF || remainder !== 8'hD2) begin
            tests_failed++;
            $display("FAIL divzero_result: got q=%h r=%h, want q=ffff r=d2", quotient, remainder);
        end
`ifdef DIV_FLAGS_EN
        tests_run++;
        if (div_zero !== 1'b1 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL divzero_flags: got dz=%b ov=%b, want 1 0", div_zero, overflow);
        end
`endif
    endtask

    task automatic test_overflow();
        int lat;
        do_op(16'h8000, 8'hFF, 1, lat);
        tests_run++;
        if (lat !== 10 || quotient !== 16'h8000 || remainder !== 8'h00) begin
            tests_failed++;
            $display("FAIL overflow_result: got lat=%0d q=%h r=%h, want lat=10 q=8000 r=00", lat, quotient, remainder);
        end
`ifdef DIV_FLAGS_EN
        tests_run++;
        if (overflow !== 1'b1 || div_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow_flags: got dz=%b ov=%b, want 0 1", div_zero, overflow);
        end
`endif
        do_op(16'h8000, 8'h01, 1, lat);
        tests_run++;
        if (lat !== 10 || quotient !== 16'h8000 || remainder !== 8'h00) begin
            tests_failed++;
            $display("FAIL minneg_by_one: got lat=%0d q=%h r=%h, want lat=10 q=8000 r=00", lat, quotient, remainder);
        end
`ifdef DIV_FLAGS_EN
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL minneg_by_one_flag: got ov=%b, want 0", overflow);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int lat;
        int hold_bad;
        do_op(16'h0064, 8'h07, 1, lat);
        tests_run++;
        if (lat !== 10 || quotient !== 16'h000E || remainder !== 8'h02) begin
            tests_failed++;
            $display("FAIL b2b_first: got lat=%0d q=%h r=%h, want lat=10 q=000e r=02", lat, quotient, remainder);
        end
        // Rising edge while ready is high must be dropped; the next edge is taken.
        dividend = 16'hFF9C;
        divisor  = 8'h07;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        lat = -1;
        hold_bad = 0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clock);
            start = 1'b0;
            if (ready === 1'b1) begin
                lat = n - 1;
                break;
            end
            if (quotient !== 16'h000E || remainder !== 8'h02) hold_bad++;
            @(posedge clock);
        end
        tests_run++;
        if (hold_bad !== 0) begin
            tests_failed++;
            $display("FAIL b2b_hold: got %0d cycles with changed outputs, want 0", hold_bad);
        end
        tests_run++;
        if (lat !== 10) begin
            tests_failed++;
            $display("FAIL b2b_latency: got %0d, want 10", lat);
        end
        tests_run++;
        if (quotient !== 16'hFFF2 || remainder !== 8'hFE) begin
            tests_failed++;
            $display("FAIL b2b_second: got q=%h r=%h, want q=fff2 r=fe", quotient, remainder);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int pulses;
        @(negedge clock);
        dividend = 16'h7FFF;
        divisor  = 8'h80;
        start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        tests_run++;
        if (quotient !== 16'h0000 || remainder !== 8'h00 || ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_clear: got q=%h r=%h rdy=%b, want q=0000 r=00 rdy=0", quotient, remainder, ready);
        end
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            if (ready === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL midreset_no_ready: got %0d ready pulses, want 0", pulses);
        end
        do_op(16'h0064, 8'h07, 1, lat);
        tests_run++;
        if (lat !== 10 || quotient !== 16'h000E || remainder !== 8'h02) begin
            tests_failed++;
            $display("FAIL midreset_restart: got lat=%0d q=%h r=%h, want lat=10 q=000e r=02", lat, quotient, remainder);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_held_start();
        test_signs();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
